cb_nway: RTL

- Parametrised N-way circular buffer.
- Each cycle it accepts up to NWAY in-order pushes at the tail and up to NWAY in-order pops at the head.
- Supports tail rollback (squash of the youngest entries) and reports occupancy status.
- Next-generation replacement for the fixed 2-in/2-out buffer; intended for ROB/instruction-queue style storage in the out-of-order pipeline.

---
 rtl/cb_nway.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cb_nway.sv
// cb_nway: parametrised N-way circular buffer.
//
// Each cycle it accepts up to NWAY in-order pushes at the tail and up to
// NWAY in-order pops at the head. It supports tail rollback (squash of the
// youngest entries) and reports occupancy status from the registered count.
//
// Parameters:
//   CB_IDX        log2 of depth (DEPTH = 2**CB_IDX)
//   CB_WIDTH      bits per entry
//   NWAY          push/pop ports per cycle (1..4, NWAY <= DEPTH)
//   ALMOST_THRESH almost_full when 1 <= free entries <= ALMOST_THRESH
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   din_en[NWAY]        push enables, enabled slots compacted in index order
//   din                 push data, slot i = din[i*CB_WIDTH +: CB_WIDTH]
//   dout_req[NWAY]      pop requests
//   move_tail           roll the tail back by tail_offset entries
//   tail_offset         number of youngest entries to squash
//   dout                slot i = entry at head+i (mod DEPTH)
//   dout_valid[NWAY]    bit i = (count > i)
//   count               occupancy 0..DEPTH
//   full/almost_full/empty  status from registered count
//   err[1:0]            (only with CB_NWAY_ERR_CHK_EN) sticky
//                       {underflow, overflow}, cleared by reset
//
// Optional feature macro: CB_NWAY_ERR_CHK_EN
module cb_nway #(
  parameter int unsigned CB_IDX        = 3,
  parameter int unsigned CB_WIDTH      = 8,
  parameter int unsigned NWAY          = 2,
  parameter int unsigned ALMOST_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NWAY-1:0]          din_en,
  input  logic [NWAY*CB_WIDTH-1:0] din,
  input  logic [NWAY-1:0]          dout_req,
  input  logic                     move_tail,
  input  logic [CB_IDX:0]          tail_offset,
  output logic [NWAY*CB_WIDTH-1:0] dout,
  output logic [NWAY-1:0]          dout_valid,
  output logic [CB_IDX:0]          count,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty
`ifdef CB_NWAY_ERR_CHK_EN
  ,
  output logic [1:0]               err
`endif
);

  localparam int unsigned    DEPTH   = 1 << CB_IDX;
  localparam logic [CB_IDX:0] DEPTH_L = (CB_IDX+1)'(DEPTH);
  localparam logic [CB_IDX:0] ONE_L   = (CB_IDX+1)'(1);
  localparam logic [CB_IDX:0] THR_L   =
    (ALMOST_THRESH >= DEPTH) ? DEPTH_L : (CB_IDX+1)'(ALMOST_THRESH);

  // State
  logic [CB_WIDTH-1:0] data_q [DEPTH];
  logic [CB_WIDTH-1:0] data_d [DEPTH];
  logic [CB_IDX-1:0]   head_q, head_d;
  logic [CB_IDX-1:0]   tail_q, tail_d;
  logic [CB_IDX:0]     count_q, count_d;

  // Per-cycle bookkeeping
  logic [CB_IDX:0]     req_cnt;   // popcount(dout_req)
  logic [CB_IDX:0]     push_cnt;  // popcount(din_en)
  logic [CB_IDX:0]     free_cnt;  // DEPTH - count at start of cycle
  logic [CB_IDX:0]     pop_n;     // P
  logic [CB_IDX:0]     acc_n;     // A
  logic [CB_IDX:0]     rb_n;      // R
  logic [CB_IDX:0]     avail_n;   // count - P, upper bound on rollback
  logic [CB_IDX:0]     wr_k;      // next compacted write offset
  logic [CB_IDX-1:0]   wr_idx;
  logic [CB_IDX-1:0]   rd_idx;

  function automatic logic [CB_IDX:0] min_c(input logic [CB_IDX:0] a,
                                            input logic [CB_IDX:0] b);
    return (a < b) ? a : b;
  endfunction

  always_comb begin
    req_cnt  = '0;
    push_cnt = '0;
    for (int unsigned i = 0; i < NWAY; i++) begin
      if (dout_req[i]) req_cnt  = req_cnt + ONE_L;
      if (din_en[i])   push_cnt = push_cnt + ONE_L;
    end

    free_cnt = DEPTH_L - count_q;
    pop_n    = min_c(req_cnt, count_q);
    avail_n  = count_q - pop_n;

    // Push credit comes only from start-of-cycle free space; a rollback
    // cycle discards every push.
    acc_n = move_tail ? '0 : min_c(push_cnt, free_cnt);
    rb_n  = move_tail ? min_c(tail_offset, avail_n) : '0;

    head_d  = head_q + pop_n[CB_IDX-1:0];
    tail_d  = tail_q + acc_n[CB_IDX-1:0] - rb_n[CB_IDX-1:0];
    count_d = count_q - pop_n + acc_n - rb_n;

    // Compact enabled slots onto tail+0, tail+1, ...; slots beyond the
    // accepted count (highest indices) fall off. Writes never hit a live
    // entry because the credit excludes same-cycle pops.
    data_d = data_q;
    wr_k   = '0;
    wr_idx = '0;
    for (int unsigned i = 0; i < NWAY; i++) begin
      if (din_en[i] && (wr_k < acc_n)) begin
        wr_idx         = tail_q + wr_k[CB_IDX-1:0];
        data_d[wr_idx] = din[i*CB_WIDTH +: CB_WIDTH];
        wr_k           = wr_k + ONE_L;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Read side and status: registered state only.
  always_comb begin
    dout       = '0;
    dout_valid = '0;
    rd_idx     = '0;
    for (int unsigned i = 0; i < NWAY; i++) begin
      rd_idx                        = head_q + CB_IDX'(i);
      dout[i*CB_WIDTH +: CB_WIDTH]  = data_q[rd_idx];
      dout_valid[i]                 = (count_q > (CB_IDX+1)'(i));
    end
  end

  assign count       = count_q;
  assign full        = (count_q == DEPTH_L);
  assign empty       = (count_q == '0);
  assign almost_full = !full && ((DEPTH_L - count_q) <= THR_L);

`ifdef CB_NWAY_ERR_CHK_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (!move_tail && (push_cnt > free_cnt)) err_d[0] = 1'b1;
    if (req_cnt > count_q)                   err_d[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
